// File: rtl/obi_sram_slave.sv
// rtl/obi_sram_slave.sv - req/gnt/rvalid word SRAM responder with grant wait states and fixed response latency
module obi_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          GNT_DELAY   = 0,
    parameter int          RSP_DELAY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] GNT_CNT = 4'(GNT_DELAY);

    logic [3:0]    r_wcnt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          r_pv  [RSP_DELAY];
    logic [31:0]   r_pd  [RSP_DELAY];
    logic          r_pe  [RSP_DELAY];

    logic [31:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_in_range;

    // Unsigned subtraction: addresses below the base wrap to huge word offsets,
    // but the explicit >= test keeps them out of range regardless.
    assign w_word     = (addr_i - ADDR_BASE) >> 2;
    assign w_idx      = w_word[AW-1:0];
    assign w_in_range = (addr_i >= ADDR_BASE) && (w_word < 32'(DEPTH_WORDS));

    assign gnt_o = req_i && !rst && (r_wcnt == GNT_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= 4'd0;
        end else if (req_i && !gnt_o) begin
            r_wcnt <= r_wcnt + 4'd1;
        end else begin
            r_wcnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_o && we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 loads zeros when nothing is granted, so idle outputs read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DELAY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'd0;
                r_pe[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= gnt_o;
            r_pe[0] <= gnt_o && !w_in_range;
            r_pd[0] <= (gnt_o && !we_i && w_in_range) ? r_mem[w_idx] : 32'd0;
            for (int i = 1; i < RSP_DELAY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign rvalid_o = r_pv[RSP_DELAY-1];
    assign rdata_o  = r_pd[RSP_DELAY-1];
    assign err_o    = r_pe[RSP_DELAY-1];

endmodule

// File: tb/tb_obi_sram_slave.sv
// tb/tb_obi_sram_slave.sv - scoreboard bench for obi_sram_slave with a word-array reference model
module tb_obi_sram_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          GNT   = 2;
    localparam int          RSP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    obi_sram_slave #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .GNT_DELAY  (GNT),
        .RSP_DELAY  (RSP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request, hold it until granted, and record the expected response.
    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        int     waits = 0;
        bit     granted = 0;
        longint a;
        longint off;
        int     idx;
        bit     inr;
        exp_t   e;
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
        while (!granted && waits <= 20) begin
            @(negedge clk);
            if (gnt_o) begin
                granted = 1;
                a   = longint'(addr);
                off = a - longint'(BASE);
                inr = (a >= longint'(BASE)) && (off / 4 < DEPTH);
                idx = inr ? int'(off / 4) : 0;
                e.due  = cyc + RSP;
                e.err  = !inr;
                e.data = 32'd0;
                if (inr && we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                end else if (inr) begin
                    e.data = model[idx];
                end
                q.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        req_i = 1'b0;
        check("gnt_wait_cycles", waits, GNT);
    endtask

    function automatic logic [31:0] rand_addr();
        int mode = $urandom_range(0, 11);
        logic [31:0] a;
        case (mode)
            8:  a = BASE + DEPTH * 4;
            9:  a = BASE - 4;
            10: a = 32'hFFFF_FFFC;
            11: a = BASE + DEPTH * 4 + 4 * $urandom_range(1, 1000);
            default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        endcase
        return a + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (rvalid_o) begin
                if (q.size() == 0) begin
                    check("no_stray_rvalid", rvalid_o, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("rsp_cycle", cyc, e.due);
                    check("rdata", rdata_o, e.data);
                    check("err", err_o, e.err);
                end
            end else begin
                check("idle_outputs_zero", {rdata_o, err_o}, 33'd0);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    check("rvalid_at_due", rvalid_o, 1'b1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = BASE; wdata_i = 32'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_gnt", gnt_o, 1'b0);
        check("reset_rvalid", rvalid_o, 1'b0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_err", err_o, 1'b0);
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;

        for (int i = 0; i < DEPTH; i++)
            do_req(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);

        do_req(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 4'hF, BASE + 32'h10, 32'd0);
        do_req(1'b1, 4'hF, BASE + 32'h20, 32'h11223344);
        do_req(1'b1, 4'b0010, BASE + 32'h20, 32'hAABBCCDD);
        do_req(1'b0, 4'h1, BASE + 32'h20, 32'd0);
        do_req(1'b1, 4'hF, BASE + DEPTH * 4, 32'hFFFFFFFF);
        do_req(1'b0, 4'hF, BASE, 32'd0);
        do_req(1'b1, 4'h0, BASE + 32'h30, 32'h5A5A5A5A);
        do_req(1'b0, 4'hF, BASE + 32'h30, 32'd0);
        do_req(1'b0, 4'hF, BASE - 4, 32'd0);
        do_req(1'b0, 4'hF, BASE + DEPTH * 4 - 4, 32'd0);

        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);
            idle($urandom_range(0, 2));
        end

        // Reset while a read is in flight: its response must never appear.
        idle(RSP + 1);
        do_req(1'b0, 4'hF, BASE + 32'h10, 32'd0);
        rst = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = BASE;
        q.delete();
        @(negedge clk);
        check("gnt_in_reset", gnt_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("gnt_in_reset", gnt_o, 1'b0);
        check("rvalid_in_reset", rvalid_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_i = 1'b0;
        idle(RSP + 2);
        do_req(1'b0, 4'hF, BASE + 32'h10, 32'd0);
        do_req(1'b0, 4'hF, BASE + 32'h20, 32'd0);

        idle(RSP + 2);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
